activ_deser_sipo: RTL
=====================

Name: activ_deser_sipo

Overview:
- Serial-in / parallel-out receiver for activation and result words sent bit-serially by the serial-MAC datapath shift registers.
- Collects Pa bits into a word, LSB first by default.
- Presents each completed word on a one-entry output buffer with a valid/ready handshake.
- Sits at the receiving end of the serial activation/result links, in front of the output writeback logic.

Parameters:
- Pa, 8, word width in bits; legal range 2..32.
- CW, $clog2(Pa), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  synchronous frame restart; clears the collect state.
- s_en  input  1  serial bit valid; in_ser is sampled when high.
- in_ser  input  1  serial data bit.
- out_par  output  Pa  completed parallel word.
- out_valid  output  1  out_par holds an unconsumed word.
- out_ready  input  1  consumer accepts out_par.
- busy  output  1  a frame is partially collected (cnt != 0).
- overrun  output  1  sticky flag: a completed word was dropped.

Behaviour:
- Reset: rst_n asynchronous, active-low; clock clk.
  - All registers clear while rst_n=0: shreg=0, cnt=0, out_par=0, out_valid=0, overrun=0, busy=0.
  - Reset mid-frame or mid-handshake discards everything; no word is emitted afterwards.
- Collect FSM (IDLE when cnt==0, COLLECT when cnt!=0):
  - Each edge with s_en=1 and start=0:
    - shreg <= {in_ser, shreg[Pa-1:1]}, so the first bit received ends in bit 0.
    - cnt increments.
  - IDLE->COLLECT on the first accepted bit.
  - On the Pa-th accepted bit (cnt==Pa-1 with s_en=1), the word is complete:
    - completed word = {in_ser, shreg[Pa-1:1]}.
    - cnt wraps to 0 and the FSM returns to IDLE.
  - s_en=0: shreg and cnt hold; gaps of any length are allowed between bits.
  - start=1: cnt<=0 and shreg<=0; overrun is cleared.
  - start and s_en high in the same cycle: start wins and that bit is discarded.
- Output buffer FSM (EMPTY when out_valid=0, FULL when out_valid=1):
  - Word completes while EMPTY: out_par <= completed word and out_valid <= 1 on the same edge. Latency is 1 edge from the last bit; the word is visible in the cycle after the last bit was sampled.
  - out_valid=1 and out_ready=1: the word is consumed at that edge and out_valid <= 0, unless a new word completes on the same edge. In that case out_par is replaced and out_valid stays 1 (zero-bubble streaming).
  - Word completes while FULL and out_ready=0: the new word is dropped, out_par and out_valid are unchanged, and overrun <= 1. The collect FSM still wraps to 0.
  - While out_valid=1, out_par is stable until the handshake completes.
  - out_ready while out_valid=0 has no effect.
  - start does not touch out_par or out_valid.
- busy = (cnt != 0), registered-derived; no combinational path from inputs to outputs.
- overrun stays set until start or reset.
- Complement to the parallel-load/rotate-right transmitter: a transmitter loaded with word W, then shifted Pa times with its serial output driving in_ser and the same s_en, yields out_par == W.

Optional Feature:
- Macro ACTIV_DESER_MSB_FIRST_EN.
- Defined: bits arrive MSB first.
  - Shift becomes shreg <= {shreg[Pa-2:0], in_ser}.
  - Completed word = {shreg[Pa-2:0], in_ser}.
  - Counting, handshake and overrun behaviour are identical.
- Undefined: LSB-first order as described above (default, matches the rotate-right transmitter).

Test Plan:
- Pa=8, out_ready=1: bits 1,0,1,0,0,1,0,1 on 8 consecutive s_en cycles -> out_par=8'hA5, out_valid=1 for exactly one cycle after the 8th edge, busy high during cycles 2..8.
- Same 0xA5 stream with random s_en gaps (0-5 idle cycles per bit) -> out_par=8'hA5, no early out_valid, cnt holds through gaps.
- out_ready=0, send 0x3C then 0xFF back-to-back -> out_par stays 8'h3C, out_valid=1, overrun=1. Then start=1 -> overrun=0, out_par still 8'h3C.
- Holding 0x3C with out_ready=1 asserted on the same edge that completes 0x81 -> out_valid stays 1, out_par=8'h81, overrun=0.
- 4 bits sent, then start (with s_en=1 same cycle), then a full 0x5A -> out_par=8'h5A, no partial word emitted. Separately, 5 bits sent, then rst_n pulse, then 0x5A -> out_par=8'h5A, all outputs 0 during reset.
- ACTIV_DESER_MSB_FIRST_EN defined: bits 1,0,1,0,0,1,0,1 -> out_par=8'hA5; bits 1,1,0,0,0,0,0,0 -> out_par=8'hC0 (8'h03 with the macro undefined).

Source files
------------

// File: rtl/activ_deser_sipo_if.sv
// rtl/activ_deser_sipo_if.sv - serial-in / parallel-out link and output handshake bundle
interface activ_deser_sipo_if #(
  parameter int Pa = 8
);
  logic          start;
  logic          s_en;
  logic          in_ser;
  logic [Pa-1:0] out_par;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          overrun;

  modport master (
    output start, s_en, in_ser, out_ready,
    input  out_par, out_valid, busy, overrun
  );

  modport slave (
    input  start, s_en, in_ser, out_ready,
    output out_par, out_valid, busy, overrun
  );
endinterface

// File: rtl/activ_deser_sipo.sv
// rtl/activ_deser_sipo.sv - bit-serial word receiver with one-entry valid/ready output buffer
// Optional macro ACTIV_DESER_MSB_FIRST_EN: bits arrive MSB first (default LSB first).
module activ_deser_sipo #(
  parameter int Pa = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  activ_deser_sipo_if.slave bus
);
  localparam int CW = $clog2(Pa);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_COLLECT = 1'b1;

  logic [Pa-1:0] shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [Pa-1:0] out_par_q, out_par_d;
  logic          out_valid_q, out_valid_d;
  logic          overrun_q, overrun_d;

  logic [0:0]    state;
  logic          accept;
  logic          word_done;
  logic [Pa-1:0] shift_word;

  // Collect state is implied by the bit counter; no separate state register.
  assign state  = (cnt_q != '0) ? S_COLLECT : S_IDLE;
  assign accept = bus.s_en & ~bus.start;
  assign word_done = accept && (state == S_COLLECT) && (cnt_q == CW'(Pa - 1));

`ifdef ACTIV_DESER_MSB_FIRST_EN
  assign shift_word = {shreg_q[Pa-2:0], bus.in_ser};
`else
  assign shift_word = {bus.in_ser, shreg_q[Pa-1:1]};
`endif

  always_comb begin
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    out_par_d   = out_par_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;

    if (bus.start) begin
      shreg_d   = '0;
      cnt_d     = '0;
      overrun_d = 1'b0;
    end else if (accept) begin
      shreg_d = shift_word;
      cnt_d   = word_done ? '0 : cnt_q + CW'(1);
    end

    // A completing word may refill the buffer on the same edge it is drained.
    if (word_done && (!out_valid_q || bus.out_ready)) begin
      out_par_d   = shift_word;
      out_valid_d = 1'b1;
    end else if (word_done) begin
      overrun_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q     <= '0;
      cnt_q       <= '0;
      out_par_q   <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      out_par_q   <= out_par_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.out_par   = out_par_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state == S_COLLECT);
  assign bus.overrun   = overrun_q;
endmodule
